// File: rtl/bank_request_arbiter_pkg.sv
// Shared definitions for the per-bank request arbiter.
//
// Contents:
//   - Default widths for the request tag, bank-local address and data.
//   - Port-index encoding: ports are numbered 1..3, and 0 means "no port".
//   - Round-robin successor function over the three ports.
//
// A queued request is packed as {tag, addr, data, wen}, with tag in the MSBs.

package bank_request_arbiter_pkg;

    localparam int TAG_W_DEF  = 2;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int NUM_PORTS  = 3;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_1    = 2'd1,
        PORT_2    = 2'd2,
        PORT_3    = 2'd3
    } port_e;

    // Cyclic order 1 -> 2 -> 3 -> 1.
    function automatic port_e next_port(input port_e p);
        case (p)
            PORT_1:  return PORT_2;
            PORT_2:  return PORT_3;
            default: return PORT_1;
        endcase
    endfunction

endpackage

// File: rtl/bank_request_arbiter_req_fifo.sv
// Synchronous FIFO that holds the queued requests of one port.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset (empties the FIFO)
//   push_i   : write wdata_i at the tail (ignored when full)
//   pop_i    : drop the head entry (ignored when empty)
//   wdata_i  : entry to enqueue
//   head_o   : current head entry (only meaningful while !empty_o)
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
//
// DEPTH must be a power of two (>= 2). The read and write pointers carry one
// extra wrap bit, so full and empty are told apart by the MSB compare.

module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: an entry is only visible once the pointers say so.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/bank_request_arbiter.sv
// Per-bank request arbiter: queues up to three masked requests per cycle in
// per-port FIFOs, serialises them round-robin onto a single-ported SRAM with
// 1-cycle read latency, and returns one tagged response per request.
//
// Ports:
//   clk, rst_n                   : clock / asynchronous active-low reset
//   portN_valid (N=1..3)         : request valid, held by producer until ready
//   portN_req_tag/addr/data_in/wen: request fields
//   portN_ready                  : FIFO N not full (registered state only)
//   bank_en/wen/addr/wdata       : SRAM access, all zero when nothing granted
//   bank_rdata                   : SRAM read data, valid cycle after a read
//   resp_valid/port/tag/wen/data : one-cycle response, port encoded 1..3,
//                                  data is read data or 0 for write acks

module bank_request_arbiter
    import bank_request_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              port1_valid,
    input  logic [TAG_W-1:0]  port1_req_tag,
    input  logic [ADDR_W-1:0] port1_addr,
    input  logic [DATA_W-1:0] port1_data_in,
    input  logic              port1_wen,
    output logic              port1_ready,

    input  logic              port2_valid,
    input  logic [TAG_W-1:0]  port2_req_tag,
    input  logic [ADDR_W-1:0] port2_addr,
    input  logic [DATA_W-1:0] port2_data_in,
    input  logic              port2_wen,
    output logic              port2_ready,

    input  logic              port3_valid,
    input  logic [TAG_W-1:0]  port3_req_tag,
    input  logic [ADDR_W-1:0] port3_addr,
    input  logic [DATA_W-1:0] port3_data_in,
    input  logic              port3_wen,
    output logic              port3_ready,

    output logic              bank_en,
    output logic              bank_wen,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata,

    output logic              resp_valid,
    output logic [1:0]        resp_port,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_wen,
    output logic [DATA_W-1:0] resp_data
);

    localparam int REQ_W = TAG_W + ADDR_W + DATA_W + 1;

    logic [REQ_W-1:0] req_in [1:3];
    logic [REQ_W-1:0] head   [1:3];
    logic [3:1]       valid;
    logic [3:1]       push;
    logic [3:1]       pop;
    logic [3:1]       full;
    logic [3:1]       empty;
    logic [3:0]       nonempty;

    port_e            ptr_q, ptr_d;
    port_e            grant_port;
    port_e            cand;
    logic [REQ_W-1:0] gnt_req;

    logic              gnt_wen;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic [TAG_W-1:0]  gnt_tag;

    logic              resp_vld_q, resp_vld_d;
    port_e             resp_port_q, resp_port_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic              resp_wen_q, resp_wen_d;

    // Request packing {tag, addr, data, wen}.
    assign req_in[1] = {port1_req_tag, port1_addr, port1_data_in, port1_wen};
    assign req_in[2] = {port2_req_tag, port2_addr, port2_data_in, port2_wen};
    assign req_in[3] = {port3_req_tag, port3_addr, port3_data_in, port3_wen};
    assign valid     = {port3_valid, port2_valid, port1_valid};

    assign port1_ready = !full[1];
    assign port2_ready = !full[2];
    assign port3_ready = !full[3];

    for (genvar g = 1; g <= NUM_PORTS; g++) begin : g_fifo
        assign push[g] = valid[g] && !full[g];
        assign pop[g]  = (grant_port == port_e'(g));

        req_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (REQ_W)
        ) u_fifo (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .wdata_i (req_in[g]),
            .head_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

    // Bit 0 stands for PORT_NONE and is never a candidate.
    assign nonempty = {~empty, 1'b0};

    // Round-robin search starting at the pointer. Candidates come from
    // registered FIFO state only, so a request pushed this edge waits a cycle.
    always_comb begin
        grant_port = PORT_NONE;
        cand       = ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_port == PORT_NONE && nonempty[cand]) begin
                grant_port = cand;
            end
            cand = next_port(cand);
        end
        ptr_d = (grant_port == PORT_NONE) ? ptr_q : next_port(grant_port);
    end

    always_comb begin
        gnt_req = '0;
        case (grant_port)
            PORT_1:  gnt_req = head[1];
            PORT_2:  gnt_req = head[2];
            PORT_3:  gnt_req = head[3];
            default: gnt_req = '0;
        endcase
    end

    assign gnt_tag  = gnt_req[REQ_W-1 -: TAG_W];
    assign gnt_addr = gnt_req[ADDR_W+DATA_W -: ADDR_W];
    assign gnt_data = gnt_req[DATA_W:1];
    assign gnt_wen  = gnt_req[0];

    // gnt_req is zero without a grant, so the bank fields fall to zero too.
    assign bank_en    = (grant_port != PORT_NONE);
    assign bank_wen   = gnt_wen;
    assign bank_addr  = gnt_addr;
    assign bank_wdata = gnt_data;

    assign resp_vld_d  = bank_en;
    assign resp_port_d = grant_port;
    assign resp_tag_d  = gnt_tag;
    assign resp_wen_d  = gnt_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= PORT_1;
            resp_vld_q  <= 1'b0;
            resp_port_q <= PORT_NONE;
            resp_tag_q  <= '0;
            resp_wen_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            resp_vld_q  <= resp_vld_d;
            resp_port_q <= resp_port_d;
            resp_tag_q  <= resp_tag_d;
            resp_wen_q  <= resp_wen_d;
        end
    end

    // Read data arrives from the SRAM in the response cycle itself.
    assign resp_valid = resp_vld_q;
    assign resp_port  = resp_port_q;
    assign resp_tag   = resp_tag_q;
    assign resp_wen   = resp_wen_q;
    assign resp_data  = (resp_vld_q && !resp_wen_q) ? bank_rdata : '0;

endmodule

// File: tb/tb_bank_request_arbiter.sv
module tb_bank_request_arbiter;

    logic        clk;
    logic        rst_n;
    logic        port1_valid, port2_valid, port3_valid;
    logic [1:0]  port1_req_tag, port2_req_tag, port3_req_tag;
    logic [9:0]  port1_addr, port2_addr, port3_addr;
    logic [15:0] port1_data_in, port2_data_in, port3_data_in;
    logic        port1_wen, port2_wen, port3_wen;
    logic        port1_ready, port2_ready, port3_ready;
    logic        bank_en, bank_wen;
    logic [9:0]  bank_addr;
    logic [15:0] bank_wdata, bank_rdata;
    logic        resp_valid, resp_wen;
    logic [1:0]  resp_port, resp_tag;
    logic [15:0] resp_data;

    int checks;
    int failures;

    bank_request_arbiter #(.DEPTH(4), .ADDR_W(10), .DATA_W(16), .TAG_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .port1_valid(port1_valid), .port1_req_tag(port1_req_tag), .port1_addr(port1_addr),
        .port1_data_in(port1_data_in), .port1_wen(port1_wen), .port1_ready(port1_ready),
        .port2_valid(port2_valid), .port2_req_tag(port2_req_tag), .port2_addr(port2_addr),
        .port2_data_in(port2_data_in), .port2_wen(port2_wen), .port2_ready(port2_ready),
        .port3_valid(port3_valid), .port3_req_tag(port3_req_tag), .port3_addr(port3_addr),
        .port3_data_in(port3_data_in), .port3_wen(port3_wen), .port3_ready(port3_ready),
        .bank_en(bank_en), .bank_wen(bank_wen), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .resp_valid(resp_valid), .resp_port(resp_port), .resp_tag(resp_tag),
        .resp_wen(resp_wen), .resp_data(resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 1-cycle read latency, preloaded with 0xBEEF at 0x005.
    logic [15:0] mem [0:1023];
    bit sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
            mem[5] <= 16'hBEEF;
            sram_init <= 1'b1;
        end else if (bank_en) begin
            if (bank_wen) mem[bank_addr] <= bank_wdata;
            else          bank_rdata <= mem[bank_addr];
        end
    end

    // Response monitor for the backpressure sequence.
    bit        mon_en = 1'b0;
    int        n_resp1, n_resp3;
    logic [1:0] p2_tags[$];
    always @(negedge clk) begin
        if (mon_en && resp_valid) begin
            case (resp_port)
                2'd1: n_resp1++;
                2'd2: p2_tags.push_back(resp_tag);
                2'd3: n_resp3++;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int n, input logic v, input logic [1:0] tag,
                         input logic [9:0] addr, input logic [15:0] data, input logic wen);
        case (n)
            1: begin port1_valid = v; port1_req_tag = tag; port1_addr = addr; port1_data_in = data; port1_wen = wen; end
            2: begin port2_valid = v; port2_req_tag = tag; port2_addr = addr; port2_data_in = data; port2_wen = wen; end
            default: begin port3_valid = v; port3_req_tag = tag; port3_addr = addr; port3_data_in = data; port3_wen = wen; end
        endcase
    endtask

    task automatic idle_all();
        for (int n = 1; n <= 3; n++) drive(n, 1'b0, 2'd0, 10'h0, 16'h0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_outputs);
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        if (check_outputs) begin
            chk("rst.ready", {29'd0, port3_ready, port2_ready, port1_ready}, 32'h7);
            chk("rst.bank", {bank_en, bank_wen, bank_addr, bank_wdata}, 32'h0);
            chk("rst.resp", {resp_valid, resp_port, resp_tag, resp_wen, resp_data}, 32'h0);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  vld;
        logic [5:0]  tags;
        logic [9:0]  addr;
        logic [15:0] data;
        logic        wen;
        logic [2:0]  exp_rdy;
        logic        exp_en;
        logic        exp_bwen;
        logic [9:0]  exp_baddr;
        logic [15:0] exp_bwdata;
        logic        exp_rv;
        logic [1:0]  exp_rport;
        logic [1:0]  exp_rtag;
        logic        exp_rwen;
        logic [15:0] exp_rdata;
    } vec_t;

    function automatic vec_t mkv(input logic [2:0] vld, input logic [5:0] tags, input logic [9:0] addr,
                                 input logic [15:0] data, input logic wen, input logic en,
                                 input logic bwen, input logic [9:0] baddr, input logic [15:0] bwdata,
                                 input logic rv, input logic [1:0] rport, input logic [1:0] rtag,
                                 input logic rwen, input logic [15:0] rdata);
        vec_t v;
        v.vld = vld; v.tags = tags; v.addr = addr; v.data = data; v.wen = wen;
        v.exp_rdy = 3'b111; v.exp_en = en; v.exp_bwen = bwen; v.exp_baddr = baddr;
        v.exp_bwdata = bwdata; v.exp_rv = rv; v.exp_rport = rport; v.exp_rtag = rtag;
        v.exp_rwen = rwen; v.exp_rdata = rdata;
        return v;
    endfunction

    vec_t vecs [13];

    int p1_acc, p2_acc, p3_acc;
    int first_low;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        idle_all();
        #2;
        do_reset(1'b1);

        //           vld     tags       addr    data      wen | en bwen baddr   bwdata   rv port tag rwen rdata
        vecs[0]  = mkv(3'b111, 6'b111001, 10'h010, 16'hA5A5, 1,  0, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[1]  = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  1, 1, 10'h010, 16'hA5A5, 0, 0, 0, 0, 16'h0000);
        vecs[2]  = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  1, 1, 10'h010, 16'hA5A5, 1, 1, 1, 1, 16'h0000);
        vecs[3]  = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  1, 1, 10'h010, 16'hA5A5, 1, 2, 2, 1, 16'h0000);
        vecs[4]  = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  0, 0, 10'h000, 16'h0000, 1, 3, 3, 1, 16'h0000);
        vecs[5]  = mkv(3'b001, 6'b000010, 10'h005, 16'h0000, 0,  0, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[6]  = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  1, 0, 10'h005, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[7]  = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  0, 0, 10'h000, 16'h0000, 1, 1, 2, 0, 16'hBEEF);
        vecs[8]  = mkv(3'b001, 6'b000000, 10'h3FF, 16'h1234, 1,  0, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);
        vecs[9]  = mkv(3'b001, 6'b000001, 10'h3FF, 16'h0000, 0,  1, 1, 10'h3FF, 16'h1234, 0, 0, 0, 0, 16'h0000);
        vecs[10] = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  1, 0, 10'h3FF, 16'h0000, 1, 1, 0, 1, 16'h0000);
        vecs[11] = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  0, 0, 10'h000, 16'h0000, 1, 1, 1, 0, 16'h1234);
        vecs[12] = mkv(3'b000, 6'b000000, 10'h000, 16'h0000, 0,  0, 0, 10'h000, 16'h0000, 0, 0, 0, 0, 16'h0000);

        // Table: contention from reset, single read, write-then-read at 0x3FF.
        for (int i = 0; i < 13; i++) begin
            for (int n = 1; n <= 3; n++)
                drive(n, vecs[i].vld[n-1], vecs[i].tags[2*n-1 -: 2], vecs[i].addr, vecs[i].data, vecs[i].wen);
            @(negedge clk);
            chk($sformatf("v%0d.ready", i), {29'd0, port3_ready, port2_ready, port1_ready}, {29'd0, vecs[i].exp_rdy});
            chk($sformatf("v%0d.bank_en", i), {31'd0, bank_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("v%0d.bank_wen", i), {31'd0, bank_wen}, {31'd0, vecs[i].exp_bwen});
            chk($sformatf("v%0d.bank_addr", i), {22'd0, bank_addr}, {22'd0, vecs[i].exp_baddr});
            chk($sformatf("v%0d.bank_wdata", i), {16'd0, bank_wdata}, {16'd0, vecs[i].exp_bwdata});
            chk($sformatf("v%0d.resp_valid", i), {31'd0, resp_valid}, {31'd0, vecs[i].exp_rv});
            chk($sformatf("v%0d.resp_port", i), {30'd0, resp_port}, {30'd0, vecs[i].exp_rport});
            chk($sformatf("v%0d.resp_tag", i), {30'd0, resp_tag}, {30'd0, vecs[i].exp_rtag});
            chk($sformatf("v%0d.resp_wen", i), {31'd0, resp_wen}, {31'd0, vecs[i].exp_rwen});
            chk($sformatf("v%0d.resp_data", i), {16'd0, resp_data}, {16'd0, vecs[i].exp_rdata});
            next_cycle();
        end

        // Fairness: ports 1 and 3 continuously busy, port 2 idle.
        do_reset(1'b0);
        drive(1, 1'b1, 2'd0, 10'h100, 16'h0, 1'b0);
        drive(3, 1'b1, 2'd0, 10'h300, 16'h0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                chk($sformatf("rr%0d.bank_en", c), {31'd0, bank_en}, 32'd1);
                chk($sformatf("rr%0d.bank_addr", c), {22'd0, bank_addr}, (c % 2 == 1) ? 32'h100 : 32'h300);
            end
            next_cycle();
        end
        idle_all();

        // Backpressure: port 2 pushes every cycle while ports 1 and 3 stay busy.
        do_reset(1'b0);
        p1_acc = 0; p2_acc = 0; p3_acc = 0; first_low = -1;
        n_resp1 = 0; n_resp3 = 0; p2_tags.delete();
        mon_en = 1'b1;
        drive(1, 1'b1, 2'd0, 10'h100, 16'h0, 1'b0);
        drive(3, 1'b1, 2'd0, 10'h300, 16'h0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            drive(2, 1'b1, 2'(p2_acc % 4), 10'h200, 16'(p2_acc), 1'b1);
            @(negedge clk);
            if (!port2_ready && first_low < 0) first_low = c;
            if (port1_ready) p1_acc++;
            if (port2_ready) p2_acc++;
            if (port3_ready) p3_acc++;
            next_cycle();
        end
        idle_all();
        repeat (20) next_cycle();
        mon_en = 1'b0;
        chk("bp.first_ready_low_cycle", 32'(first_low), 32'd5);
        chk("bp.p1_count", 32'(n_resp1), 32'(p1_acc));
        chk("bp.p3_count", 32'(n_resp3), 32'(p3_acc));
        chk("bp.p2_count", 32'(p2_tags.size()), 32'(p2_acc));
        for (int k = 0; k < p2_tags.size(); k++)
            chk($sformatf("bp.p2_tag%0d", k), {30'd0, p2_tags[k]}, 32'(k % 4));

        // Asynchronous reset in the middle of a cycle with work queued.
        do_reset(1'b0);
        for (int n = 1; n <= 3; n++) drive(n, 1'b1, 2'(n), 10'h020, 16'h5555, 1'b1);
        next_cycle();
        drive(3, 1'b0, 2'd0, 10'h0, 16'h0, 1'b0);
        next_cycle();
        idle_all();
        #2;
        chk("mid.bank_en_before", {31'd0, bank_en}, 32'd1);
        chk("mid.resp_valid_before", {31'd0, resp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.bank", {bank_en, bank_wen, bank_addr, bank_wdata}, 32'h0);
        chk("mid.resp", {resp_valid, resp_port, resp_tag, resp_wen, resp_data}, 32'h0);
        chk("mid.ready", {29'd0, port3_ready, port2_ready, port1_ready}, 32'h7);
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post%0d.resp_valid", c), {31'd0, resp_valid}, 32'd0);
            chk($sformatf("post%0d.bank_en", c), {31'd0, bank_en}, 32'd0);
            next_cycle();
        end
        drive(3, 1'b1, 2'd3, 10'h005, 16'h0, 1'b0);
        next_cycle();
        idle_all();
        @(negedge clk);
        chk("post.grant_addr", {bank_en, 21'd0, bank_addr}, {1'b1, 21'd0, 10'h005});
        next_cycle();
        @(negedge clk);
        chk("post.resp", {resp_valid, resp_port, resp_tag, resp_wen, resp_data},
            {1'b1, 2'd3, 2'd3, 1'b0, 16'hBEEF});
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bank_request_arbiter.md
Name: bank_request_arbiter

Overview:
- Sits directly downstream of the per-bank validity mask, one instance per bank (4 total).
- Accepts up to three masked requests per cycle (one per port) into per-port FIFOs.
- Serialises the queued requests with a round-robin arbiter onto one single-ported bank SRAM (1-cycle read latency).
- Returns a tagged response per serviced request to the response crossbar.

Parameters:
- DEPTH, 4, entries per port FIFO (power of two, ≥2)
- ADDR_W, 10, bank-local word address width
- DATA_W, 16, data width
- TAG_W, 2, request tag width

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- portN_valid  input  1  masked request valid, N=1..3
- portN_req_tag  input  TAG_W  masked request tag
- portN_addr  input  ADDR_W  masked bank-local address
- portN_data_in  input  DATA_W  masked write data
- portN_wen  input  1  1=write, 0=read
- portN_ready  output  1  FIFO N not full
- bank_en  output  1  SRAM access strobe
- bank_wen  output  1  SRAM write enable
- bank_addr  output  ADDR_W  SRAM address
- bank_wdata  output  DATA_W  SRAM write data
- bank_rdata  input  DATA_W  SRAM read data, valid the cycle after bank_en & !bank_wen
- resp_valid  output  1  response strobe, one cycle
- resp_port  output  2  originating port, 1..3 (0 never driven while resp_valid)
- resp_tag  output  TAG_W  echoed request tag
- resp_wen  output  1  1 = write acknowledge
- resp_data  output  DATA_W  read data; 0 for write acks

Behaviour:
- Reset (asynchronous, rst_n low):
  - All FIFOs empty; round-robin pointer = port1; response pipeline register cleared.
  - During reset: portN_ready=1; bank_en=0, bank_wen=0, bank_addr=0, bank_wdata=0; resp_valid=0, resp_port=0, resp_tag=0, resp_wen=0, resp_data=0.
- Enqueue: push FIFO N on a rising edge where portN_valid & portN_ready. portN_ready = !fullN, purely from registered state. Producers hold requests while ready=0.
- Arbitration, combinational each cycle from registered FIFO state:
  - Candidates are the non-empty FIFOs.
  - Search starts at the pointer and proceeds in the cyclic order pointer, pointer+1, pointer+2.
  - The first candidate found is granted and its head is popped at the next edge.
  - After a grant the pointer becomes the grantee+1 (mod 3). With no grant the pointer holds.
- No bypass: a request pushed at edge E is first eligible in the cycle after E, so it is granted at earliest at edge E+1.
- Bank drive:
  - bank_en = any grant.
  - bank_wen, bank_addr, bank_wdata come from the granted head.
  - All bank_* outputs are 0 when there is no grant.
- Response:
  - At the granting edge, register {valid=1, port, tag, wen}.
  - In the following cycle, resp_valid=1 with those fields.
  - resp_data = bank_rdata for reads, 0 for writes.
  - Request-to-response latency is 2 cycles minimum. There is no response backpressure.
- Throughput: 1 request per cycle per bank. A port whose FIFO is non-empty is granted within 3 consecutive grant cycles.
- Simultaneous push and pop on the same FIFO is allowed. When the FIFO is full, ready is already 0, so no push happens that cycle even if a pop frees an entry.
- Pointer wrap: DEPTH is a power of two, so FIFO read/write pointers are log2(DEPTH)+1 bits and full/empty come from the MSB compare.
- Reset mid-operation: queued requests and the in-flight response are discarded; no response is emitted after rst_n deasserts.
- Ordering: per-port order is preserved. Cross-port order follows arbitration only.
- Read-after-write on the same address through different ports: ordered by grant order only.

Decomposition:
- Shared package: TAG_W, bank ADDR_W and DATA_W defaults, the port-index encoding (1..3), and the request struct/field order {tag, addr, data, wen}.
- Natural sub-module: req_fifo (parameterised sync FIFO, DEPTH×(TAG_W+ADDR_W+DATA_W+1)), instantiated three times.
- The arbiter and response register stay in the top module.

Test Plan:
- Single read: port1 addr=0x005 tag=2 pushed at edge 0; SRAM holds 0xBEEF at 0x005 -> bank_en=1, bank_addr=0x005 in cycle 1; in cycle 2 resp_valid=1, port=1, tag=2, resp_data=0xBEEF.
- Three-way contention: ports 1, 2, 3 all push a write in the same cycle from reset -> grants in order 1, 2, 3 on consecutive cycles; three write acks with resp_wen=1, resp_data=0.
- Full/backpressure: DEPTH=4; port2 pushes every cycle while ports 1 and 3 keep their FIFOs non-empty -> port2_ready=0 after its FIFO holds 4 entries; no entry lost or duplicated; order of port2 tags 0, 1, 2, 3, 0 preserved.
- Round-robin fairness: port1 continuous, port3 continuous, port2 idle -> grants alternate 1, 3, 1, 3, and no port waits more than one cycle between grants.
- Write then read same address: port1 writes 0x1234 to 0x3FF, then port1 reads 0x3FF -> read response data 0x1234; address 0x3FF (all-ones) is exercised.
- Reset mid-operation: 5 requests queued, rst_n pulled low asynchronously mid-cycle -> outputs 0 immediately; after release, no resp_valid until new pushes, and all portN_ready=1.
